// File: rtl/uart_report_sched.sv
// Round-robin scheduler: grants one of four requesters, captures its 16-bit sample and
// streams a 4-byte report (header, data hi, data lo, XOR checksum) through a start/busy UART.
module uart_report_sched #(
   parameter logic [7:0] HDR_BASE = 8'hA0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [63:0] req_data,
   output logic [3:0]  ack,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic [15:0] frame_cnt,
   output logic        active
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [1:0]  last_q, last_d;
   logic [1:0]  ch_q, ch_d;
   logic [15:0] sample_q, sample_d;
   logic        first_q, first_d;
   logic [3:0]  ack_q, ack_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_start_q, tx_start_d;
   logic [15:0] frame_q, frame_d;
   logic        active_q, active_d;

   logic        win_vld;
   logic [1:0]  win;
   logic [1:0]  cand;
   logic [1:0]  nxt_idx;

   function automatic logic [7:0] pkt_byte(input logic [1:0] i, input logic [1:0] ch,
                                           input logic [15:0] s);
      logic [7:0] hdr;
      hdr = HDR_BASE | {6'b0, ch};
      case (i)
         2'd0:    pkt_byte = hdr;
         2'd1:    pkt_byte = s[15:8];
         2'd2:    pkt_byte = s[7:0];
         default: pkt_byte = hdr ^ s[15:8] ^ s[7:0];
      endcase
   endfunction

   // Rotating priority search starting just after the last grant.
   always_comb begin
      win_vld = 1'b0;
      win     = 2'd0;
      cand    = 2'd0;
      for (int unsigned k = 1; k <= 4; k++) begin
         cand = 2'(last_q + 2'(k));
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win     = cand;
         end
      end
   end

   assign nxt_idx = 2'(idx_q + 2'd1);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      last_d     = last_q;
      ch_d       = ch_q;
      sample_d   = sample_q;
      first_d    = first_q;
      ack_d      = 4'b0000;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      frame_d    = frame_q;

      case (state_q)
         IDLE: begin
            if (win_vld) begin
               sample_d   = req_data[{win, 4'b0000} +: 16];
               ch_d       = win;
               last_d     = win;
               ack_d      = 4'(4'b0001 << win);
               idx_d      = 2'd0;
               tx_start_d = 1'b1;
               tx_data_d  = pkt_byte(2'd0, win, 16'h0000);
               state_d    = SEND;
            end
         end
         SEND: begin
            first_d = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            // First WAIT cycle is the transmitter's chance to raise busy.
            if (first_q) begin
               first_d = 1'b0;
            end else if (!tx_busy) begin
               if (idx_q == 2'd3) begin
                  frame_d = 16'(frame_q + 16'd1);
                  state_d = IDLE;
               end else begin
                  idx_d      = nxt_idx;
                  tx_start_d = 1'b1;
                  tx_data_d  = pkt_byte(nxt_idx, ch_q, sample_q);
                  state_d    = SEND;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      active_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= 2'd0;
         last_q     <= 2'd3;
         ch_q       <= 2'd0;
         sample_q   <= 16'h0000;
         first_q    <= 1'b0;
         ack_q      <= 4'b0000;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         frame_q    <= 16'h0000;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         ch_q       <= ch_d;
         sample_q   <= sample_d;
         first_q    <= first_d;
         ack_q      <= ack_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         frame_q    <= frame_d;
         active_q   <= active_d;
      end
   end

   assign ack       = ack_q;
   assign tx_data   = tx_data_q;
   assign tx_start  = tx_start_q;
   assign frame_cnt = frame_q;
   assign active    = active_q;

endmodule

// File: tb/tb_uart_report_sched.sv
// Bench for uart_report_sched: UART busy model, requesters that drop req on ack,
// and a scoreboard of expected grants and report bytes.
module tb_uart_report_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = 4'b0000;
   logic [63:0] req_data = 64'h0;
   logic [3:0]  ack;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy = 1'b0;
   logic [15:0] frame_cnt;
   logic        active;

   uart_report_sched dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .ack       (ack),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .frame_cnt (frame_cnt),
      .active    (active)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]       req;
      logic [3:0]       rereq;
      logic [3:0][15:0] data;
      logic [7:0][3:0]  grants;
      int               busy;
      int               n;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   int          busy_len = 480;
   int          bcnt = 0;
   int          cyc = 0;
   int          fall_cyc = 0;
   int          bytes_seen = 0;
   int          model_frames = 0;
   logic        prev_start = 1'b0;
   logic        prev_busy = 1'b0;
   logic [3:0]  rereq_mask = 4'b0000;
   logic [3:0]  rereq_pend = 4'b0000;
   logic [15:0] chan_data [4];
   int          gq [$];
   logic [7:0]  bq [$];
   vec_t        vecs [5];

   // Transmitter: busy rises the cycle after tx_start and holds for busy_len cycles.
   always @(posedge clk) begin
      if (tx_start) begin
         tx_busy <= 1'b1;
         bcnt    <= busy_len;
      end else if (bcnt > 1) begin
         bcnt <= bcnt - 1;
      end else if (bcnt == 1) begin
         bcnt    <= 0;
         tx_busy <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_data();
      req_data = {chan_data[3], chan_data[2], chan_data[1], chan_data[0]};
   endtask

   // One cycle: sample on the falling edge, run requesters and scoreboard.
   task automatic step();
      int         g;
      logic [7:0] hdr, hi, lo;
      @(negedge clk);
      cyc++;
      if (rst) begin
         prev_start = 1'b0;
         prev_busy  = tx_busy;
         rereq_pend = 4'b0000;
      end else begin
         if (ack != 4'b0000) begin
            chk("ack_with_header_start", 32'(tx_start), 32'd1);
            chk("frame_cnt_at_ack", 32'(frame_cnt), 32'(model_frames));
            if (gq.size() == 0) begin
               chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
               g = gq.pop_front();
               chk("ack_grant", 32'(ack), 32'(4'(4'b0001 << g)));
               hdr = 8'hA0 | 8'(g);
               hi  = chan_data[g][15:8];
               lo  = chan_data[g][7:0];
               bq.push_back(hdr);
               bq.push_back(hi);
               bq.push_back(lo);
               bq.push_back(hdr ^ hi ^ lo);
               model_frames++;
               chan_data[g] = 16'($urandom);
               req[g]       = 1'b0;
               rereq_pend   = rereq_pend | (rereq_mask & 4'(4'b0001 << g));
               if (gq.size() == 0) begin
                  req        = 4'b0000;
                  rereq_pend = 4'b0000;
               end
            end
         end else if (rereq_pend != 4'b0000) begin
            req        = req | rereq_pend;
            rereq_pend = 4'b0000;
         end
         if (tx_start) begin
            chk("start_prev_busy_active", 32'({prev_start, tx_busy, active}), 32'b001);
            if (bq.size() == 0) chk("byte_expected", 32'(bq.size()), 32'd1);
            else chk("tx_byte", 32'(tx_data), 32'(bq.pop_front()));
            if (bytes_seen % 4 != 0) chk("turnaround", 32'(cyc), 32'(fall_cyc + 1));
            bytes_seen++;
         end
         if (!tx_busy && prev_busy) fall_cyc = cyc;
         prev_start = tx_start;
         prev_busy  = tx_busy;
      end
      drive_data();
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      req        = 4'b0000;
      rereq_mask = 4'b0000;
      step();
      chk("reset_outputs", 32'({ack, tx_start, tx_data, frame_cnt, active}), 32'd0);
      step();
      rst          = 1'b0;
      model_frames = 0;
      bytes_seen   = 0;
      bq.delete();
      gq.delete();
   endtask

   task automatic wait_done(input int budget);
      int t = 0;
      while (!(gq.size() == 0 && bq.size() == 0 && !active) && t < budget) begin
         step();
         t++;
      end
      chk("done_in_budget", 32'(t < budget), 32'd1);
   endtask

   initial begin
      int t;
      for (int k = 0; k < 4; k++) chan_data[k] = 16'h0;

      vecs[0] = '{req: 4'b0010, rereq: 4'b0000, data: {16'h0000, 16'h0000, 16'h1234, 16'h0000},
                  grants: 32'h0000_0001, busy: 480, n: 1};
      vecs[1] = '{req: 4'b1111, rereq: 4'b0000, data: {16'h0F0F, 16'hA55A, 16'h0000, 16'hFFFF},
                  grants: 32'h0000_3210, busy: 480, n: 4};
      vecs[2] = '{req: 4'b0101, rereq: 4'b0101, data: {16'h3333, 16'hC0DE, 16'h1111, 16'h8001},
                  grants: 32'h0020_2020, busy: 30, n: 6};
      vecs[3] = '{req: 4'b1010, rereq: 4'b0000, data: {16'h7E57, 16'h0000, 16'h00FF, 16'h0000},
                  grants: 32'h0000_0031, busy: 3, n: 2};
      vecs[4] = '{req: 4'b1001, rereq: 4'b1001, data: {16'h4321, 16'h0000, 16'h0000, 16'h9ABC},
                  grants: 32'h0000_3030, busy: 8, n: 4};

      for (int v = 0; v < 5; v++) begin
         do_reset();
         for (int k = 0; k < 4; k++) chan_data[k] = vecs[v].data[k];
         drive_data();
         busy_len   = vecs[v].busy;
         rereq_mask = vecs[v].rereq;
         for (int i = 0; i < vecs[v].n; i++) gq.push_back(int'(vecs[v].grants[i]));
         req = vecs[v].req;
         wait_done(20000);
         repeat (3) step();
         chk("frame_cnt_final", 32'(frame_cnt), 32'(vecs[v].n));
         chk("active_idle", 32'(active), 32'd0);
      end

      // Reset while waiting on byte 2, then a fresh packet from channel 2.
      do_reset();
      busy_len     = 480;
      chan_data[2] = 16'hBEEF;
      drive_data();
      gq.push_back(2);
      req = 4'b0100;
      t = 0;
      while (bytes_seen < 3 && t < 5000) begin
         step();
         t++;
      end
      chk("reached_byte2", 32'(bytes_seen), 32'd3);
      repeat (5) step();
      rst = 1'b1;
      step();
      chk("midrst_outputs", 32'({ack, tx_start, frame_cnt, active}), 32'd0);
      rst          = 1'b0;
      bq.delete();
      gq.delete();
      bytes_seen   = 0;
      model_frames = 0;
      t = 0;
      while (tx_busy && t < 1000) begin
         step();
         t++;
      end
      chk("tx_idle_after_rst", 32'(tx_busy), 32'd0);
      chan_data[2] = 16'h5A5A;
      drive_data();
      gq.push_back(2);
      req = 4'b0100;
      t = 0;
      while (!tx_start && t < 50) begin
         step();
         t++;
      end
      chk("fresh_header", 32'(tx_data), 32'h0A2);
      wait_done(5000);
      repeat (3) step();
      chk("frame_cnt_after_rst", 32'(frame_cnt), 32'd1);

      // Many short packets with a fast transmitter and data changing right after ack.
      do_reset();
      busy_len     = 1;
      chan_data[0] = 16'h0001;
      drive_data();
      rereq_mask = 4'b0001;
      for (int i = 0; i < 1500; i++) gq.push_back(0);
      req = 4'b0001;
      wait_done(30000);
      repeat (3) step();
      chk("frame_cnt_many", 32'(frame_cnt), 32'd1500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
